sram_bank_array: RTL
====================

SRAM_BANK_ARRAY -- requirements
Module: sram_bank_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter NUM_WMASKS, default 4, write-mask lanes; DATA_WIDTH divisible by NUM_WMASKS.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-004 SHALL have parameter NUM_BANKS, default 2, power of two, 1..DEPTH; bank = addr[log2(NUM_BANKS)-1:0] (interleaved).
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 clr  input  1  one-cycle request to re-zero all storage.
REQ-009 init_done  output  1  high when storage is zeroed and ports are usable.
REQ-010 p0_valid  input  1  port-0 request present.
REQ-011 p0_ready  output  1  port-0 request accepted this cycle.
REQ-012 p0_we  input  1  1 = write, 0 = read.
REQ-013 p0_wmask  input  NUM_WMASKS  per-lane write enable, lane i = bits [i*DATA_WIDTH/NUM_WMASKS +: DATA_WIDTH/NUM_WMASKS].
REQ-014 p0_addr  input  ADDR_WIDTH  port-0 word address.
REQ-015 p0_wdata  input  DATA_WIDTH  port-0 write data.
REQ-016 p0_rvalid / p0_rdata  output  1 / DATA_WIDTH  port-0 read response.
REQ-017 p1_valid / p1_ready  input / output  1 / 1  port-1 (read-only) handshake.
REQ-018 p1_addr  input  ADDR_WIDTH  port-1 word address.
REQ-019 p1_rvalid / p1_rdata  output  1 / DATA_WIDTH  port-1 read response.

Function
REQ-020 FSM states INIT, RUN; reset enters INIT with clear counter = 0.
REQ-021 INIT: each cycle writes zero to row cnt of every bank in parallel; cnt increments; after row DEPTH/NUM_BANKS-1, next state RUN. INIT lasts exactly DEPTH/NUM_BANKS cycles.
REQ-022 init_done = 1 only in RUN; p0_ready = p1_ready = 0 in INIT.
REQ-023 clr sampled in RUN moves FSM to INIT with cnt = 0 next cycle; requests valid in the same cycle are not accepted.
REQ-024 In RUN, p0_ready = 1 whenever state is RUN (port 0 never stalls).
REQ-025 In RUN, p1_ready = 1 unless p0_valid = 1 and p0 bank equals p1 bank (port 0 wins conflicts).
REQ-026 Accepted write: lanes with wmask bit 1 updated at that clock edge; other lanes unchanged; no rvalid generated.
REQ-027 Accepted read: rvalid = 1 and rdata = word exactly one cycle after acceptance; rvalid = 0 otherwise.
REQ-028 rdata holds last returned value while rvalid = 0.
REQ-029 p0 write and p1 read to different banks in the same cycle both complete; p1 returns pre-existing contents of its address.
REQ-030 Same-bank conflict where p1 stalls and retries next cycle: p1 SHALL return data including the p0 write.
REQ-031 Requests with valid = 0 cause no storage change and no rvalid.

Reset
REQ-032 On rst_n = 0 at a clock edge: state INIT, cnt = 0, init_done = 0, p0_ready = p1_ready = 0, p0_rvalid = p1_rvalid = 0, p0_rdata = p1_rdata = 0.
REQ-033 Reset asserted mid-INIT or mid-RUN restarts INIT from cnt = 0; reads in flight are dropped (no rvalid).
REQ-034 Storage contents are undefined only until first INIT completes; never observable via ports before init_done.

Verification
REQ-035 Reset, defaults -> init_done rises exactly 128 cycles after rst_n deassert; p0 read of addr 0x05 -> rdata 0x00000000.
REQ-036 p0 write addr 0x00 data 0xAAAAAAAA mask 4'b1111, then write 0x55555555 mask 4'b0101 -> read returns 0xAA55AA55 one cycle after accept.
REQ-037 Same cycle: p0 write addr 0x02 data 0x12345678, p1 read addr 0x03 (different bank) -> both ready; p1_rdata = prior value next cycle.
REQ-038 Same cycle: p0 write addr 0x04 data 0xDEADBEEF, p1 read addr 0x06 (same bank) -> p1_ready = 0; retried next cycle, returns addr 0x06 contents; read of 0x04 returns 0xDEADBEEF.
REQ-039 After writes, pulse clr -> init_done low for 128 cycles, ready low; then all previously written addresses read 0x00000000.
REQ-040 Assert rst_n = 0 for one cycle during INIT at cnt = 60 -> INIT restarts; init_done rises 128 cycles after reset release.

Source files
------------

// File: rtl/sram_bank_array_if.sv
// Request/response bundle for the two-port banked SRAM: port 0 reads/writes, port 1 reads only.
interface sram_bank_array_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WMASKS = 4,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  clr;
  logic                  init_done;
  logic                  p0_valid;
  logic                  p0_ready;
  logic                  p0_we;
  logic [NUM_WMASKS-1:0] p0_wmask;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;
  logic                  p1_valid;
  logic                  p1_ready;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  modport master (
    output clr, p0_valid, p0_we, p0_wmask, p0_addr, p0_wdata, p1_valid, p1_addr,
    input  init_done, p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata
  );

  modport slave (
    input  clr, p0_valid, p0_we, p0_wmask, p0_addr, p0_wdata, p1_valid, p1_addr,
    output init_done, p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata
  );
endinterface

// File: rtl/sram_bank_array.sv
// Word-interleaved banked SRAM with a zeroing INIT sweep (one row of every bank per cycle);
// port 0 (read/write) wins same-bank conflicts against port 1 (read only).
module sram_bank_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WMASKS = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_bank_array_if.slave  bus
);
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned ROWS   = DEPTH / NUM_BANKS;
  localparam int unsigned LANE_W = DATA_WIDTH / NUM_WMASKS;
  localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NUM_BANKS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(ROWS - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_p0_rvalid, r_p1_rvalid;
  logic [DATA_WIDTH-1:0] r_p0_rdata, r_p1_rdata;

  logic w_open, w_same_bank, w_p0_acc, w_p1_acc;

  // A clr cycle accepts nothing: the sweep starts on the next edge.
  assign w_open      = (r_state == StRun) && !bus.clr;
  assign w_same_bank = (bus.p0_addr & BANK_MASK) == (bus.p1_addr & BANK_MASK);
  assign w_p0_acc    = bus.p0_valid && bus.p0_ready;
  assign w_p1_acc    = bus.p1_valid && bus.p1_ready;

  assign bus.init_done = (r_state == StRun);
  assign bus.p0_ready  = w_open;
  assign bus.p1_ready  = w_open && !(bus.p0_valid && w_same_bank);
  assign bus.p0_rvalid = r_p0_rvalid;
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rvalid = r_p1_rvalid;
  assign bus.p1_rdata  = r_p1_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StInit: begin
          if (r_cnt == LAST_ROW) begin
            r_state <= StRun;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (bus.clr) begin
            r_state <= StInit;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Storage is not reset; the INIT sweep defines it before any port can reach it.
  always_ff @(posedge clk) begin
    if (rst_n && r_state == StInit) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        r_mem[ADDR_WIDTH'(int'(r_cnt) * NUM_BANKS + b)] <= '0;
      end
    end else if (w_p0_acc && bus.p0_we) begin
      for (int unsigned l = 0; l < NUM_WMASKS; l++) begin
        if (bus.p0_wmask[l]) begin
          r_mem[bus.p0_addr][l*LANE_W +: LANE_W] <= bus.p0_wdata[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_p0_rvalid <= w_p0_acc && !bus.p0_we;
      r_p1_rvalid <= w_p1_acc;
      if (w_p0_acc && !bus.p0_we) r_p0_rdata <= r_mem[bus.p0_addr];
      if (w_p1_acc)               r_p1_rdata <= r_mem[bus.p1_addr];
    end
  end
endmodule
